// File: rtl/br_write_sequencer_if.sv
// Write-port, scoreboard and hazard signals of the register-bank write sequencer.
// The master side drives the requests; the slave side is the sequencer.
interface br_write_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ALU_valid;
    logic              ALU_ready;
    logic [ADDR_W-1:0] ALU_reg;
    logic [DATA_W-1:0] ALU_data;
    logic              MEM_valid;
    logic [ADDR_W-1:0] MEM_reg;
    logic [DATA_W-1:0] MEM_data;
    logic              Issue_valid;
    logic [ADDR_W-1:0] Issue_reg;
    logic [ADDR_W-1:0] R_register_1;
    logic [ADDR_W-1:0] R_register_2;
    logic              Hazard_1;
    logic              Hazard_2;
    logic              RegEn;
    logic [ADDR_W-1:0] W_register;
    logic [DATA_W-1:0] W_data;

    modport master (
        output ALU_valid, ALU_reg, ALU_data, MEM_valid, MEM_reg, MEM_data,
               Issue_valid, Issue_reg, R_register_1, R_register_2,
        input  ALU_ready, Hazard_1, Hazard_2, RegEn, W_register, W_data
    );

    modport slave (
        input  ALU_valid, ALU_reg, ALU_data, MEM_valid, MEM_reg, MEM_data,
               Issue_valid, Issue_reg, R_register_1, R_register_2,
        output ALU_ready, Hazard_1, Hazard_2, RegEn, W_register, W_data
    );
endinterface

// File: rtl/br_write_sequencer.sv
// Merges ALU and load write-back onto the single register-bank write port,
// buffering ALU writes that lose to loads, and tracks pending writes for RAW stalls.
module br_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst_n,
    br_write_sequencer_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t              buf_q [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      count;
    logic [NREG-1:0]  pending, pend_nxt;
    logic             empty, alu_acc, push, pop, sel_vld;
    wr_t              sel;

    assign empty         = (count == '0);
    assign bus.ALU_ready = (count != (PW+1)'(DEPTH));
    assign alu_acc       = bus.ALU_valid && bus.ALU_ready;
    // An accepted ALU write only bypasses the buffer when nothing older or higher priority exists.
    assign push          = alu_acc && (bus.MEM_valid || !empty);

    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        pop     = 1'b0;
        if (bus.MEM_valid) begin
            sel_vld = 1'b1;
            sel     = '{rd: bus.MEM_reg, data: bus.MEM_data};
        end else if (!empty) begin
            sel_vld = 1'b1;
            sel     = buf_q[rd_ptr];
            pop     = 1'b1;
        end else if (alu_acc) begin
            sel_vld = 1'b1;
            sel     = '{rd: bus.ALU_reg, data: bus.ALU_data};
        end
    end

    // Issue sets after the retire clear so a same-register set wins.
    always_comb begin
        pend_nxt = pending;
        if (bus.RegEn) pend_nxt[bus.W_register] = 1'b0;
        if (bus.Issue_valid && bus.Issue_reg != '0) pend_nxt[bus.Issue_reg] = 1'b1;
    end

    assign bus.Hazard_1 = pending[bus.R_register_1] && (bus.R_register_1 != '0);
    assign bus.Hazard_2 = pending[bus.R_register_2] && (bus.R_register_2 != '0);

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= '{rd: bus.ALU_reg, data: bus.ALU_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RegEn      <= 1'b0;
            bus.W_register <= '0;
            bus.W_data     <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            pending        <= '0;
        end else begin
            // Register-0 writes are consumed but never reach the bank.
            bus.RegEn <= sel_vld && (sel.rd != '0);
            if (sel_vld && sel.rd != '0) begin
                bus.W_register <= sel.rd;
                bus.W_data     <= sel.data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pending <= pend_nxt;
        end
    end
endmodule

// File: tb/tb_br_write_sequencer.sv
// Random and directed stimulus for br_write_sequencer, checked every cycle
// against a queue-based model of the write-back rules.
module tb_br_write_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } mw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    br_write_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

    br_write_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: all accepted ALU writes enter an in-order queue; each cycle a load
    // wins, otherwise the oldest ALU write retires.
    mw_t               mq[$];
    logic [31:0]       m_pend;
    logic              m_regen;
    logic [ADDR_W-1:0] m_wreg;
    logic [DATA_W-1:0] m_wdata;

    always @(posedge clk or negedge rst_n) begin : model
        mw_t w;
        bit wv, rdy;
        logic [31:0] p;
        if (!rst_n) begin
            mq.delete();
            m_pend  <= '0;
            m_regen <= 1'b0;
            m_wreg  <= '0;
            m_wdata <= '0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (ifc.ALU_valid && rdy) mq.push_back('{ifc.ALU_reg, ifc.ALU_data});
            wv = 1'b0;
            w  = '{'0, '0};
            if (ifc.MEM_valid) begin
                w = '{ifc.MEM_reg, ifc.MEM_data};
                wv = 1'b1;
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                wv = 1'b1;
            end
            p = m_pend;
            if (m_regen) p[m_wreg] = 1'b0;
            if (ifc.Issue_valid && ifc.Issue_reg != 0) p[ifc.Issue_reg] = 1'b1;
            m_pend  <= p;
            m_regen <= wv && (w.rd != 0);
            if (wv && w.rd != 0) begin
                m_wreg  <= w.rd;
                m_wdata <= w.data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("regen", 32'(ifc.RegEn), 32'(m_regen));
            if (m_regen) begin
                chk("w_register", 32'(ifc.W_register), 32'(m_wreg));
                chk("w_data", ifc.W_data, m_wdata);
            end
            chk("alu_ready", 32'(ifc.ALU_ready), 32'(mq.size() < DEPTH));
            chk("hazard_1", 32'(ifc.Hazard_1),
                32'(m_pend[ifc.R_register_1] && ifc.R_register_1 != 0));
            chk("hazard_2", 32'(ifc.Hazard_2),
                32'(m_pend[ifc.R_register_2] && ifc.R_register_2 != 0));
        end
    end

    task automatic idle();
        ifc.ALU_valid   = 1'b0;
        ifc.MEM_valid   = 1'b0;
        ifc.Issue_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        ifc.ALU_valid = 1'b1; ifc.ALU_reg = r; ifc.ALU_data = d;
    endtask

    task automatic mem(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        ifc.MEM_valid = 1'b1; ifc.MEM_reg = r; ifc.MEM_data = d;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_regen"}, 32'(ifc.RegEn), 32'd0);
        chk({tag, "_ready"}, 32'(ifc.ALU_ready), 32'd1);
        chk({tag, "_hz1"}, 32'(ifc.Hazard_1), 32'd0);
        chk({tag, "_hz2"}, 32'(ifc.Hazard_2), 32'd0);
    endtask

    initial begin
        idle();
        ifc.ALU_reg = '0; ifc.ALU_data = '0; ifc.MEM_reg = '0; ifc.MEM_data = '0;
        ifc.Issue_reg = '0; ifc.R_register_1 = '0; ifc.R_register_2 = '0;
        #12;
        chk_reset("rst0");
        chk("rst0_wreg", 32'(ifc.W_register), 32'd0);
        chk("rst0_wdata", ifc.W_data, 32'd0);
        step();
        rst_n = 1'b1;

        // Single ALU write bypasses the buffer
        alu(5'd5, 32'hDEADBEEF); step(); idle();
        chk("bypass_en", 32'(ifc.RegEn), 32'd1);
        chk("bypass_reg", 32'(ifc.W_register), 32'd5);
        chk("bypass_data", ifc.W_data, 32'hDEADBEEF);
        step();
        chk("bypass_gap", 32'(ifc.RegEn), 32'd0);

        // Load beats ALU in the same cycle, ALU follows
        alu(5'd3, 32'h11); mem(5'd4, 32'h22); step(); idle();
        chk("arb_reg1", 32'(ifc.W_register), 32'd4);
        chk("arb_data1", ifc.W_data, 32'h22);
        step();
        chk("arb_en2", 32'(ifc.RegEn), 32'd1);
        chk("arb_reg2", 32'(ifc.W_register), 32'd3);
        chk("arb_data2", ifc.W_data, 32'h11);
        step();

        // Six back-to-back loads fill the buffer, then four ALU writes drain in order
        for (int i = 0; i < 6; i++) begin
            alu(5'(10 + i), 32'(100 + i)); mem(5'(20 + i), 32'(200 + i)); step();
            chk("fill_reg", 32'(ifc.W_register), 32'(20 + i));
            chk("fill_ready", 32'(ifc.ALU_ready), 32'(i < 3));
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            step();
            chk("drain_reg", 32'(ifc.W_register), 32'(10 + j));
            chk("drain_data", ifc.W_data, 32'(100 + j));
        end
        step();
        chk("drain_done", 32'(ifc.RegEn), 32'd0);

        // Scoreboard on r7
        ifc.R_register_1 = 5'd7; ifc.R_register_2 = 5'd0;
        ifc.Issue_valid = 1'b1; ifc.Issue_reg = 5'd7; step(); idle();
        chk("sb_set", 32'(ifc.Hazard_1), 32'd1);
        alu(5'd7, 32'h77); step(); idle();
        chk("sb_wr_en", 32'(ifc.RegEn), 32'd1);
        chk("sb_held", 32'(ifc.Hazard_1), 32'd1);
        step();
        chk("sb_clr", 32'(ifc.Hazard_1), 32'd0);
        ifc.Issue_valid = 1'b1; ifc.Issue_reg = 5'd7; step(); idle();
        alu(5'd7, 32'h78); step(); idle();
        ifc.Issue_valid = 1'b1; ifc.Issue_reg = 5'd7; step(); idle();
        chk("sb_setwins", 32'(ifc.Hazard_1), 32'd1);
        step();
        chk("sb_setwins2", 32'(ifc.Hazard_1), 32'd1);
        alu(5'd7, 32'h79); step(); idle(); step();
        chk("sb_clr2", 32'(ifc.Hazard_1), 32'd0);

        // Register 0
        alu(5'd0, 32'hFFFFFFFF); step(); idle();
        chk("r0_drop", 32'(ifc.RegEn), 32'd0);
        ifc.Issue_valid = 1'b1; ifc.Issue_reg = 5'd0; step(); idle();
        ifc.R_register_1 = 5'd0; ifc.R_register_2 = 5'd0; step();
        chk("r0_hz1", 32'(ifc.Hazard_1), 32'd0);
        chk("r0_hz2", 32'(ifc.Hazard_2), 32'd0);

        // Random traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            ifc.ALU_valid    = ($urandom_range(0, 99) < 60);
            ifc.ALU_reg      = 5'($urandom_range(0, 7));
            ifc.ALU_data     = $urandom;
            ifc.MEM_valid    = ($urandom_range(0, 99) < 35);
            ifc.MEM_reg      = 5'($urandom_range(0, 7));
            ifc.MEM_data     = $urandom;
            ifc.Issue_valid  = ($urandom_range(0, 99) < 40);
            ifc.Issue_reg    = 5'($urandom_range(0, 7));
            ifc.R_register_1 = 5'($urandom_range(0, 7));
            ifc.R_register_2 = 5'($urandom_range(0, 7));
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                chk_reset("rst_mid");
                step();
                chk_reset("rst_hold");
                rst_n = 1'b1;
                idle();
                step();
                chk("rst_nopulse", 32'(ifc.RegEn), 32'd0);
            end else begin
                step();
            end
        end
        idle();
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
